gate_enable_sequencer: RTL and testbench

upstream stage producing the two gate enables that qualify the clock in the AND-gated segment-driver tile (gate_a -> ui_in[0] path, gate_b -> ui_in[1] path).

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles before a debounced level flips (legal range 2..255).
REQ-002 SHALL have parameter BLINK_DIV, default 1000: cycles per blink phase (legal range 2..65535).
REQ-003 SHALL have parameter BURST_LEN, default 8: gate-high cycles per burst (legal range 1..255).
REQ-004 SHALL provide: clk  input  1  single clock, all flops on its rising edge.
REQ-005 SHALL provide: rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL provide: ena  input  1  tile enable; 0 forces gates low and freezes mode logic.
REQ-007 SHALL provide: btn_a  input  1  raw asynchronous push-button A.
REQ-008 SHALL provide: btn_b  input  1  raw asynchronous push-button B.
REQ-009 SHALL provide: mode  input  2  00 direct, 01 toggle, 10 blink, 11 burst.
REQ-010 SHALL provide: gate_a  output  1  registered gate enable A.
REQ-011 SHALL provide: gate_b  output  1  registered gate enable B.
REQ-012 SHALL provide: state  output  2  burst FSM state: 00 IDLE, 01 BURST_A, 10 BURST_B.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-014 SHALL debounce each synced button: counter increments while synced != debounced; clears on any agreement; at count DEBOUNCE_CYCLES-1 with disagreement, debounced flips and counter clears.
REQ-015 SHALL generate a one-cycle press pulse on each debounced 0->1 transition; releases generate nothing.
REQ-016 SHALL in direct mode drive gate_x = debounced_x, registered; latency from the edge first sampling a raw change to the gate change is DEBOUNCE_CYCLES+3 edges, counting the sampling edge as the first.
REQ-017 SHALL in toggle mode invert gate_a on each A press and gate_b on each B press; simultaneous presses toggle both.
REQ-018 SHALL in blink mode run prescaler 0..BLINK_DIV-1 with a phase bit that toggles on wrap; gate_a = (phase==0), gate_b = (phase==1); buttons ignored.
REQ-019 SHALL never assert gate_a and gate_b together in blink or burst mode.
REQ-020 SHALL in burst mode, from IDLE, go to BURST_A on A press or BURST_B on B press (A wins if simultaneous); the selected gate is high for exactly BURST_LEN cycles starting the edge after entry, then FSM returns to IDLE with the gate low.
REQ-021 SHALL ignore presses while in BURST_A/BURST_B, including a press on the final burst cycle.
REQ-022 SHALL on any change of mode: drive both gates low on the next edge, clear toggle flags, prescaler, phase and burst counter, and force state to IDLE; new mode takes effect from the following edge.
REQ-023 SHALL while ena=0: drive gates 0, hold prescaler, phase, toggle flags, burst FSM and counter; synchronizers and debouncers keep running; presses during ena=0 are discarded.
REQ-024 SHALL report state=00 in all modes other than burst.

Reset
REQ-025 SHALL on rst=1 at a rising edge clear gate_a, gate_b, state, synchronizers, debounced levels, debounce counters, toggle flags, prescaler, phase and burst counter to 0.
REQ-026 SHALL let rst override ena, mode and buttons, including mid-burst and mid-debounce; no press pulse is produced for a button already held when rst deasserts until it is released and re-pressed.

Verification (DEBOUNCE_CYCLES=4, BLINK_DIV=5, BURST_LEN=3)
REQ-027 Direct: btn_a 0->1 held -> gate_a rises on the 7th edge; 2-cycle glitch on btn_b -> gate_b stays 0.
REQ-028 Toggle: three clean A presses -> gate_a 1,0,1; simultaneous A+B press -> both gates invert on the same edge.
REQ-029 Blink: enter mode 10 -> gate_a high 5 cycles, gate_b high 5 cycles, repeating; never both high.
REQ-030 Burst: A press -> state 01, gate_a high exactly 3 cycles, state 00; B press during burst -> no BURST_B afterwards.
REQ-031 Reset/mode change mid-burst: rst=1 at burst cycle 2 -> next edge

---
 rtl/gate_enable_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_gate_enable_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_enable_sequencer.sv
// Gate enable sequencer: conditions two push-buttons and derives the two clock-gate
// enables (direct, toggle, blink, burst) for the AND-gated segment-driver tile.
module gate_enable_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLINK_DIV       = 1000,
    parameter int BURST_LEN       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic [1:0] mode,
    output logic       gate_a,
    output logic       gate_b,
    output logic [1:0] state
);

    localparam logic [7:0]  DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] PRESC_LAST = 16'(BLINK_DIV - 1);
    localparam logic [7:0]  BURST_LAST = 8'(BURST_LEN);

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_BURST  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BURST_A = 2'b01,
        ST_BURST_B = 2'b10
    } burst_state_e;

    logic [1:0] btn_raw;
    logic [1:0] db_lvl;
    logic [1:0] press;
    logic [1:0] sync_fill_q;

    assign btn_raw = {btn_b, btn_a};

    // Marks when the synchronizer outputs reflect real post-reset samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_fill_q <= 2'b00;
        end else begin
            sync_fill_q <= {sync_fill_q[0], 1'b1};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic       sync1_q;
            logic       sync2_q;
            logic       db_q;
            logic       db_d;
            logic       press_q;
            logic       press_d;
            logic       arm_q;
            logic       arm_d;
            logic [7:0] cnt_q;
            logic [7:0] cnt_d;

            // A press only counts once the button has been seen released after reset.
            always_comb begin
                db_d    = db_q;
                cnt_d   = 8'd0;
                press_d = 1'b0;
                arm_d   = arm_q | (sync_fill_q[1] & ~sync2_q);
                if (sync2_q != db_q) begin
                    if (cnt_q == DB_LAST) begin
                        db_d    = sync2_q;
                        press_d = sync2_q & arm_q;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    db_q    <= 1'b0;
                    cnt_q   <= 8'd0;
                    press_q <= 1'b0;
                    arm_q   <= 1'b0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                    db_q    <= db_d;
                    cnt_q   <= cnt_d;
                    press_q <= press_d;
                    arm_q   <= arm_d;
                end
            end

            assign db_lvl[gi] = db_q;
            assign press[gi]  = press_q;
        end
    endgenerate

    logic [1:0]   mode_q;
    logic [1:0]   mode_d;
    burst_state_e state_q;
    burst_state_e state_d;
    logic [7:0]   burst_cnt_q;
    logic [7:0]   burst_cnt_d;
    logic [15:0]  presc_q;
    logic [15:0]  presc_d;
    logic         phase_q;
    logic         phase_d;
    logic [1:0]   tog_q;
    logic [1:0]   tog_d;
    logic [1:0]   gate_q;
    logic [1:0]   gate_d;
    logic         mode_chg;

    assign mode_chg = (mode != mode_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_DIRECT;
            state_q     <= ST_IDLE;
            burst_cnt_q <= 8'd0;
            presc_q     <= 16'd0;
            phase_q     <= 1'b0;
            tog_q       <= 2'b00;
            gate_q      <= 2'b00;
        end else begin
            mode_q      <= mode_d;
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            presc_q     <= presc_d;
            phase_q     <= phase_d;
            tog_q       <= tog_d;
            gate_q      <= gate_d;
        end
    end

    // With ena low everything holds; the mode register also holds, so a mode
    // change made while disabled is acted on when the tile is re-enabled.
    always_comb begin
        mode_d      = mode_q;
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        presc_d     = presc_q;
        phase_d     = phase_q;
        tog_d       = tog_q;
        if (ena) begin
            mode_d = mode;
            if (mode_chg) begin
                state_d     = ST_IDLE;
                burst_cnt_d = 8'd0;
                presc_d     = 16'd0;
                phase_d     = 1'b0;
                tog_d       = 2'b00;
            end else begin
                case (mode_q)
                    MODE_TOGGLE: tog_d = tog_q ^ press;
                    MODE_BLINK: begin
                        if (presc_q == PRESC_LAST) begin
                            presc_d = 16'd0;
                            phase_d = ~phase_q;
                        end else begin
                            presc_d = presc_q + 16'd1;
                        end
                    end
                    MODE_BURST: begin
                        case (state_q)
                            ST_IDLE: begin
                                burst_cnt_d = 8'd0;
                                if (press[0]) begin
                                    state_d = ST_BURST_A;
                                end else if (press[1]) begin
                                    state_d = ST_BURST_B;
                                end
                            end
                            ST_BURST_A, ST_BURST_B: begin
                                if (burst_cnt_q == BURST_LAST) begin
                                    state_d     = ST_IDLE;
                                    burst_cnt_d = 8'd0;
                                end else begin
                                    burst_cnt_d = burst_cnt_q + 8'd1;
                                end
                            end
                            default: begin
                                state_d     = ST_IDLE;
                                burst_cnt_d = 8'd0;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // Burst gate is high while the counter runs 0..BURST_LEN-1 after entry.
    always_comb begin
        gate_d = 2'b00;
        if (ena && !mode_chg) begin
            case (mode_q)
                MODE_DIRECT: gate_d = db_lvl;
                MODE_TOGGLE: gate_d = tog_d;
                MODE_BLINK:  gate_d = phase_q ? 2'b10 : 2'b01;
                MODE_BURST: begin
                    if (burst_cnt_q != BURST_LAST) begin
                        if (state_q == ST_BURST_A) begin
                            gate_d = 2'b01;
                        end else if (state_q == ST_BURST_B) begin
                            gate_d = 2'b10;
                        end
                    end
                end
                default: gate_d = 2'b00;
            endcase
        end
    end

    assign gate_a = gate_q[0];
    assign gate_b = gate_q[1];
    assign state  = state_q;

endmodule

// File: tb/tb_gate_enable_sequencer.sv
// Bench for gate_enable_sequencer: directed button/mode/ena sequences checked against a
// cycle-level behavioural model plus hand-computed literal expectations.
module tb_gate_enable_sequencer;
    localparam int DB  = 4;
    localparam int DIV = 5;
    localparam int BL  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       btn_a;
    logic       btn_b;
    logic [1:0] mode;
    logic       gate_a;
    logic       gate_b;
    logic [1:0] state;

    int n_checks = 0;
    int n_err    = 0;

    gate_enable_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .BLINK_DIV      (DIV),
        .BURST_LEN      (BL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .btn_a (btn_a),
        .btn_b (btn_b),
        .mode  (mode),
        .gate_a(gate_a),
        .gate_b(gate_b),
        .state (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: inputs sampled at the rising edge, outputs predicted for after it.
    bit          m_on = 1'b0;
    bit          m_s1 [2];
    bit          m_s2 [2];
    bit          m_db [2];
    bit          m_arm [2];
    bit          m_press [2];
    logic [31:0] m_hist [2];
    int          m_fill;
    logic [1:0]  m_mode;
    bit   [1:0]  m_tog;
    int          m_blink_t;
    int          m_st;
    int          m_bt;
    bit          m_ga;
    bit          m_gb;

    always @(posedge clk) begin
        bit          raw [2];
        bit          press_now [2];
        bit          new_press;
        bit          s2_old;
        logic [31:0] mask;
        raw[0] = btn_a;
        raw[1] = btn_b;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_arm[b] = 0; m_press[b] = 0;
                m_hist[b] = 32'd0;
            end
            m_fill = 0; m_mode = 2'b00; m_tog = 2'b00; m_blink_t = 0;
            m_st = 0; m_bt = 0; m_ga = 0; m_gb = 0;
            m_on = 1'b1;
        end else begin
            press_now[0] = m_press[0];
            press_now[1] = m_press[1];
            if (!ena) begin
                m_ga = 0; m_gb = 0;
            end else if (mode != m_mode) begin
                m_mode = mode; m_tog = 2'b00; m_blink_t = 0; m_st = 0; m_bt = 0;
                m_ga = 0; m_gb = 0;
            end else begin
                case (m_mode)
                    2'b00: begin m_ga = m_db[0]; m_gb = m_db[1]; end
                    2'b01: begin
                        m_tog[0] = m_tog[0] ^ press_now[0];
                        m_tog[1] = m_tog[1] ^ press_now[1];
                        m_ga = m_tog[0]; m_gb = m_tog[1];
                    end
                    2'b10: begin
                        m_ga = ((m_blink_t / DIV) % 2) == 0;
                        m_gb = !m_ga;
                        m_blink_t++;
                    end
                    default: begin
                        if (m_st == 0) begin
                            m_ga = 0; m_gb = 0;
                            if (press_now[0]) begin m_st = 1; m_bt = 0; end
                            else if (press_now[1]) begin m_st = 2; m_bt = 0; end
                        end else begin
                            m_bt++;
                            if (m_bt <= BL) begin
                                m_ga = (m_st == 1); m_gb = (m_st == 2);
                            end else begin
                                m_st = 0; m_ga = 0; m_gb = 0;
                            end
                        end
                    end
                endcase
            end
            // Debounced level flips once the last DB synced samples all disagree with it.
            mask = (32'd1 << DB) - 32'd1;
            for (int b = 0; b < 2; b++) begin
                s2_old    = m_s2[b];
                m_hist[b] = {m_hist[b][30:0], s2_old};
                new_press = 0;
                if ((m_hist[b] & mask) == (m_db[b] ? 32'd0 : mask)) begin
                    m_db[b]   = !m_db[b];
                    new_press = m_db[b] && m_arm[b];
                end
                if (m_fill >= 2 && !s2_old) m_arm[b] = 1;
                m_press[b] = new_press;
                m_s2[b]    = m_s1[b];
                m_s1[b]    = raw[b];
            end
            m_fill++;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("cyc_gate_a", int'(gate_a), int'(m_ga));
            check("cyc_gate_b", int'(gate_b), int'(m_gb));
            check("cyc_state", int'(state), m_st);
        end
    end

    task automatic press(input bit a, input bit b);
        btn_a = a; btn_b = b;
        cyc(8);
        btn_a = 0; btn_b = 0;
        cyc(12);
    endtask

    logic [19:0] pa, pb, sa;
    logic [9:0]  qa, qb;
    bit          seen;

    initial begin
        rst = 1; ena = 1; btn_a = 0; btn_b = 0; mode = 2'b00;
        cyc(3);
        check("reset_gate_a", int'(gate_a), 0);
        check("reset_gate_b", int'(gate_b), 0);
        check("reset_state", int'(state), 0);
        rst = 0;
        cyc(5);

        // Direct mode: DB+3 = 7 edge latency, short glitch filtered
        btn_a = 1;
        cyc(6);
        check("direct_a_edge6", int'(gate_a), 0);
        cyc(1);
        check("direct_a_edge7", int'(gate_a), 1);
        btn_b = 1; cyc(2); btn_b = 0; cyc(10);
        check("direct_b_glitch", int'(gate_b), 0);
        check("direct_a_held", int'(gate_a), 1);
        btn_a = 0; cyc(10);
        check("direct_a_release", int'(gate_a), 0);

        // Toggle mode
        mode = 2'b01; cyc(2);
        press(1, 0); check("toggle_a_1", int'(gate_a), 1);
        press(1, 0); check("toggle_a_2", int'(gate_a), 0);
        press(1, 0); check("toggle_a_3", int'(gate_a), 1);
        check("toggle_b_idle", int'(gate_b), 0);
        btn_a = 1; btn_b = 1;
        cyc(6);
        check("toggle_ab_pre", int'({gate_b, gate_a}), 2'b01);
        cyc(1);
        check("toggle_ab_post", int'({gate_b, gate_a}), 2'b10);
        cyc(1); btn_a = 0; btn_b = 0; cyc(12);

        // Blink mode
        mode = 2'b10; cyc(1);
        check("blink_entry", int'({gate_b, gate_a}), 0);
        pa = '0; pb = '0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            pa = {pa[18:0], gate_a};
            pb = {pb[18:0], gate_b};
        end
        check("blink_pat_a", int'(pa), int'(20'b11111000001111100000));
        check("blink_pat_b", int'(pb), int'(20'b00000111110000011111));
        check("blink_exclusive", int'(pa & pb), 0);
        cyc(2);
        ena = 0;
        qa = '0; qb = '0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            qa = {qa[8:0], gate_a};
            qb = {qb[8:0], gate_b};
        end
        check("ena_off_gates", int'(qa | qb), 0);
        ena = 1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            qa = {qa[8:0], gate_a};
            qb = {qb[8:0], gate_b};
        end
        check("ena_resume_a", int'(qa), int'(10'b1110000011));
        check("ena_resume_b", int'(qb), int'(10'b0001111100));

        // Burst mode: A burst, B press on the final burst cycle ignored
        mode = 2'b11; cyc(2);
        btn_a = 1; sa = '0; pa = '0; seen = 0;
        for (int c = 1; c <= 20; c++) begin
            cyc(1);
            sa = {sa[18:0], state == 2'b01};
            pa = {pa[18:0], gate_a};
            if (state == 2'b10 || gate_b) seen = 1;
            if (c == 4) btn_b = 1;
            if (c == 5) btn_a = 0;
            if (c == 9) btn_b = 0;
        end
        check("burst_state_a", int'(sa), int'(20'b00000011110000000000));
        check("burst_gate_a", int'(pa), int'(20'b00000001110000000000));
        check("burst_no_b", int'(seen), 0);
        cyc(12);

        // Reset mid-burst with button still held through reset
        btn_a = 1; cyc(9);
        check("burst_cycle2_gate", int'(gate_a), 1);
        check("burst_cycle2_state", int'(state), 1);
        rst = 1; cyc(1);
        check("rst_mid_burst_gate", int'(gate_a), 0);
        check("rst_mid_burst_state", int'(state), 0);
        cyc(1); rst = 0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1);
            if (state != 2'b00) seen = 1;
        end
        check("held_btn_ignored", int'(seen), 0);
        btn_a = 0; cyc(14);

        // Mode change mid-burst
        btn_a = 1; cyc(5); btn_a = 0; cyc(4);
        check("burst2_cycle2_gate", int'(gate_a), 1);
        mode = 2'b00; cyc(1);
        check("modechg_gate_a", int'(gate_a), 0);
        check("modechg_state", int'(state), 0);
        cyc(15);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
